// File: rtl/cdb_rr_arbiter.sv
// Common-data-bus arbiter: one maximum-priority channel plus N_REQ ordinary
// channels arbitrated round-robin (or fixed priority), feeding a single
// registered output slot with valid/ready backpressure and a synchronous flush.
module cdb_rr_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 64,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      flush_i,
  input  logic                      max_prio_valid_i,
  input  logic [DATA_W-1:0]         max_prio_data_i,
  output logic                      max_prio_ready_o,
  input  logic [N_REQ-1:0]          valid_i,
  input  logic [N_REQ*DATA_W-1:0]   data_i,
  output logic [N_REQ-1:0]          ready_o,
  output logic                      cdb_valid_o,
  input  logic                      cdb_ready_i,
  output logic [DATA_W-1:0]         cdb_data_o,
  output logic [$clog2(N_REQ+1)-1:0] cdb_src_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SRC_W = $clog2(N_REQ + 1);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

  logic              load_en;
  logic              any_valid;
  logic [PTR_W-1:0]  grant_idx;
  logic [DATA_W-1:0] ord_data;
  logic              mp_xfer;
  logic              ord_xfer;

  // The slot can accept a new entry when empty or being drained this cycle;
  // a flush blocks every transfer.
  assign load_en = (!cdb_valid_q || cdb_ready_i) && !flush_i;

  // Pick the ordinary-channel candidate: first requester at or after ptr_q
  // (round-robin) or lowest requesting index (fixed). Scanning from the far
  // end down lets the nearest requester overwrite earlier matches.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_v;
    grant_idx = '0;
    idx       = 0;
    idx_v     = '0;
    any_valid = |valid_i;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (ROUND_ROBIN != 0) begin
        idx = int'(ptr_q) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
      end else begin
        idx = k;
      end
      idx_v = PTR_W'(idx);
      if (valid_i[idx_v]) grant_idx = idx_v;
    end
  end

  // Payload of the arbitrated ordinary channel.
  assign ord_data = data_i[int'(grant_idx)*DATA_W +: DATA_W];

  // Combinational handshakes: max-priority ready tracks load_en on its own,
  // an ordinary channel only gets ready when max-priority is idle.
  always_comb begin
    ready_o          = '0;
    max_prio_ready_o = load_en;
    mp_xfer          = max_prio_valid_i && load_en;
    ord_xfer         = !max_prio_valid_i && any_valid && load_en;
    if (ord_xfer) ready_o[grant_idx] = 1'b1;
  end

  // Next state for the output slot and the round-robin pointer.
  always_comb begin
    cdb_valid_d = cdb_valid_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    ptr_d       = ptr_q;
    if (flush_i) begin
      cdb_valid_d = 1'b0;
      ptr_d       = '0;
    end else if (mp_xfer) begin
      cdb_valid_d = 1'b1;
      cdb_data_d  = max_prio_data_i;
      cdb_src_d   = '0;
    end else if (ord_xfer) begin
      cdb_valid_d = 1'b1;
      cdb_data_d  = ord_data;
      cdb_src_d   = SRC_W'(grant_idx) + SRC_W'(1);
      if (ROUND_ROBIN != 0) begin
        if (grant_idx == PTR_W'(N_REQ - 1)) ptr_d = '0;
        else                                ptr_d = grant_idx + PTR_W'(1);
      end else begin
        ptr_d = '0;
      end
    end else if (cdb_ready_i) begin
      cdb_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign cdb_valid_o = cdb_valid_q;
  assign cdb_data_o  = cdb_data_q;
  assign cdb_src_o   = cdb_src_q;

endmodule
